// File: rtl/ema_sample_feeder.sv
// Flow-controlled issue sequencer: buffers upstream samples in a FIFO, issues them
// one at a time to the EMA core and holds each result behind a ready/valid register.
module ema_sample_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [14:0] alpha_i,
  output logic [15:0] ema_x_o,
  output logic [14:0] ema_alpha_o,
  output logic        ema_valid_o,
  input  logic        ema_bussy_i,
  input  logic        ema_valid_i,
  input  logic [15:0] ema_y_i,
  output logic [15:0] r_data_o,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  output logic        error_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [TW-1:0] tcnt;
  logic          push;
  logic          pop;

  assign s_ready_o = (count < FULL);
  assign push      = s_valid_i && s_ready_o;
  // Issue gate: a new result may only be produced once the held one is leaving.
  assign pop       = (state == IDLE) && (count != '0) && !ema_bussy_i &&
                     (!r_valid_o || r_ready_i);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= s_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      ema_x_o     <= '0;
      ema_alpha_o <= '0;
      ema_valid_o <= 1'b0;
      r_data_o    <= '0;
      r_valid_o   <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      ema_valid_o <= 1'b0;
      // Capture in WAIT below overrides this clear when both happen together.
      if (r_valid_o && r_ready_i) r_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ema_x_o     <= mem[rptr];
            ema_alpha_o <= alpha_i;
            ema_valid_o <= 1'b1;
            tcnt        <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (ema_valid_i) begin
            r_data_o  <= ema_y_i;
            r_valid_o <= 1'b1;
            state     <= IDLE;
          end else if (tcnt == TLAST) begin
            error_o <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ema_sample_feeder.sv
// Bench for ema_sample_feeder: queue-based reference model checked every cycle,
// a behavioural EMA core stand-in, and directed scenarios with literal expectations.
module tb_ema_sample_feeder;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [14:0] alpha_i = '0;
  logic [15:0] ema_x_o;
  logic [14:0] ema_alpha_o;
  logic        ema_valid_o;
  logic        ema_bussy_i = 1'b0;
  logic        ema_valid_i = 1'b0;
  logic [15:0] ema_y_i = '0;
  logic [15:0] r_data_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b1;
  logic        error_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ema_sample_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .alpha_i(alpha_i),
    .ema_x_o(ema_x_o), .ema_alpha_o(ema_alpha_o), .ema_valid_o(ema_valid_o),
    .ema_bussy_i(ema_bussy_i), .ema_valid_i(ema_valid_i), .ema_y_i(ema_y_i),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .error_o(error_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Core stand-in: answers resp_lat cycles after a strobe (0 = never answers).
  int          resp_lat = 3;
  int          core_cnt = 0;
  logic [15:0] y_q[$];
  bit          stray_req = 0;
  logic [15:0] stray_y = '0;

  initial forever begin
    @(posedge clk);
    #2;
    ema_valid_i = 1'b0;
    if (ema_valid_o) core_cnt = resp_lat;
    else if (core_cnt > 1) core_cnt--;
    else if (core_cnt == 1) begin
      core_cnt    = 0;
      ema_valid_i = 1'b1;
      ema_y_i     = (y_q.size() > 0) ? y_q.pop_front() : 16'h0;
    end
    if (stray_req) begin
      stray_req   = 0;
      ema_valid_i = 1'b1;
      ema_y_i     = stray_y;
    end
  end

  // Reference model: FIFO as a queue, one outstanding sample, result slot.
  logic [15:0] m_fifo[$];
  logic [15:0] issued_x[$];
  int          issued = 0;
  bit          m_wait = 0;
  int          m_n = 0;
  bit          m_rv = 0;
  logic [15:0] m_rd = '0;
  bit          m_err = 0;
  bit          p_push = 0, p_rready = 0, p_evi = 0, p_evo = 0;
  logic [15:0] p_d = '0, p_y = '0;
  logic [14:0] p_alpha = '0;

  always @(negedge clk) begin
    bit cap;
    if (rst) begin
      m_fifo.delete();
      m_wait = 0; m_n = 0; m_rv = 0; m_rd = '0; m_err = 0;
      chk("rst_x", 32'(ema_x_o), 0);
      chk("rst_alpha", 32'(ema_alpha_o), 0);
      chk("rst_evalid", 32'(ema_valid_o), 0);
      chk("rst_rdata", 32'(r_data_o), 0);
      chk("rst_rvalid", 32'(r_valid_o), 0);
      chk("rst_error", 32'(error_o), 0);
      chk("rst_sready", 32'(s_ready_o), 1);
      p_push = 0; p_rready = 0; p_evi = 0; p_evo = 0;
    end else begin
      if (p_push) m_fifo.push_back(p_d);
      cap = p_evi && m_wait && (m_n >= 1);
      if (cap) begin
        m_rv = 1; m_rd = p_y; m_wait = 0;
      end else if (m_rv && p_rready) begin
        m_rv = 0;
      end
      if (m_wait) begin
        m_n++;
        if (m_n > TIMEOUT) begin
          m_err = 1; m_wait = 0;
        end
      end
      if (ema_valid_o) begin
        chk("issue_single_cycle", 32'(p_evo), 0);
        chk("issue_one_outstanding", 32'(m_wait), 0);
        chk("issue_nonempty", 32'(m_fifo.size() > 0), 1);
        if (m_fifo.size() > 0) chk("issue_x", 32'(ema_x_o), 32'(m_fifo.pop_front()));
        chk("issue_alpha", 32'(ema_alpha_o), 32'(p_alpha));
        issued++;
        issued_x.push_back(ema_x_o);
        m_wait = 1; m_n = 0;
      end
      chk("s_ready", 32'(s_ready_o), 32'(m_fifo.size() < DEPTH));
      chk("r_valid", 32'(r_valid_o), 32'(m_rv));
      if (m_rv) chk("r_data", 32'(r_data_o), 32'(m_rd));
      chk("error", 32'(error_o), 32'(m_err));
      p_push   = s_valid_i && s_ready_o;
      p_d      = s_data_i;
      p_rready = r_ready_i;
      p_evi    = ema_valid_i;
      p_y      = ema_y_i;
      p_evo    = ema_valid_o;
      p_alpha  = alpha_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] d);
    int n = 0;
    bit acc;
    s_valid_i = 1'b1;
    s_data_i  = d;
    forever begin
      acc = s_ready_o;
      step();
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("push_accept_timeout", 32'(n), 0);
        break;
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (!(issued == target && !m_wait && !r_valid_o) && n < 400) begin
      step();
      n++;
    end
    chk(name, 32'(n < 400), 1);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    @(negedge clk);
    while (!ema_valid_o && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    chk(name, 32'(ema_valid_o), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int rv_seen;
    logic [15:0] got[$];
    bit was;

    // Reset
    @(negedge clk);
    chk("reset_sready", 32'(s_ready_o), 1);
    chk("reset_evalid", 32'(ema_valid_o), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_sready", 32'(s_ready_o), 1);
    step();

    // Single sample
    resp_lat = 3; y_q.push_back(16'd30); alpha_i = 15'd9830; r_ready_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 16'd100;
    step();
    s_valid_i = 1'b0;
    @(negedge clk); chk("ss_no_issue_k", 32'(ema_valid_o), 0);
    step();
    @(negedge clk);
    chk("ss_issue_k1", 32'(ema_valid_o), 1);
    chk("ss_x", 32'(ema_x_o), 100);
    chk("ss_alpha", 32'(ema_alpha_o), 9830);
    step();
    @(negedge clk); chk("ss_strobe_ends", 32'(ema_valid_o), 0);
    chk("ss_x_held", 32'(ema_x_o), 100);
    step(); step();
    @(negedge clk); chk("ss_rv_early", 32'(r_valid_o), 0);
    step();
    @(negedge clk);
    chk("ss_rv", 32'(r_valid_o), 1);
    chk("ss_rdata", 32'(r_data_o), 30);
    step();
    @(negedge clk);
    chk("ss_rv_one_cycle", 32'(r_valid_o), 0);
    chk("ss_error", 32'(error_o), 0);
    step();

    // FIFO full and wrap
    ema_bussy_i = 1'b1; resp_lat = 2; alpha_i = 15'd1234; base = issued;
    for (int i = 1; i <= 8; i++) begin
      y_q.push_back(16'(i * 3));
      push(16'(i));
    end
    y_q.push_back(16'd27);
    chk("full_ready_low", 32'(s_ready_o), 0);
    s_valid_i = 1'b1; s_data_i = 16'd9;
    repeat (3) step();
    chk("full_ready_held", 32'(s_ready_o), 0);
    chk("full_no_issue", 32'(issued - base), 0);
    ema_bussy_i = 1'b0;
    push(16'd9);
    wait_done(base + 9, "full_done");
    for (int i = 0; i < 9; i++) chk("full_order", 32'(issued_x[base + i]), 32'(i + 1));

    // Backpressure
    r_ready_i = 1'b0; ema_bussy_i = 1'b1; base = issued;
    y_q.push_back(16'd11); y_q.push_back(16'd22); y_q.push_back(16'd33);
    push(16'd40); push(16'd41); push(16'd42);
    ema_bussy_i = 1'b0;
    repeat (30) step();
    chk("bp_one_issue", 32'(issued - base), 1);
    chk("bp_held_valid", 32'(r_valid_o), 1);
    chk("bp_held_data", 32'(r_data_o), 11);
    r_ready_i = 1'b1;
    wait_done(base + 3, "bp_done");
    chk("bp_order1", 32'(issued_x[base + 1]), 41);
    chk("bp_order2", 32'(issued_x[base + 2]), 42);

    // Timeout
    resp_lat = 0; ema_bussy_i = 1'b1; base = issued;
    push(16'd500); push(16'd600);
    ema_bussy_i = 1'b0;
    wait_strobe("to_first_issue");
    resp_lat = 3; y_q.push_back(16'd77);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_error_not_yet", 32'(error_o), 0);
    @(negedge clk);
    chk("to_error_set", 32'(error_o), 1);
    step();
    wait_done(base + 2, "to_done");
    chk("to_next_issued", 32'(issued_x[base + 1]), 600);
    chk("to_error_sticky", 32'(error_o), 1);

    // Stray result and reset mid-operation
    stray_y = 16'hFFFB; stray_req = 1;
    repeat (4) step();
    chk("stray_ignored", 32'(r_valid_o), 0);
    resp_lat = 5; y_q.push_back(16'd99); ema_bussy_i = 1'b1; base = issued;
    push(16'd70); push(16'd71); push(16'd72); push(16'd73);
    ema_bussy_i = 1'b0;
    wait_strobe("rst_issue");
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_error", 32'(error_o), 0);
    chk("mid_rst_x", 32'(ema_x_o), 0);
    chk("mid_rst_sready", 32'(s_ready_o), 1);
    step();
    rst = 1'b0;
    rv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      rv_seen += 32'(r_valid_o);
      step();
    end
    chk("late_result_ignored", 32'(rv_seen), 0);
    chk("fifo_dropped", 32'(issued - base), 1);
    chk("post_rst_sready", 32'(s_ready_o), 1);

    // Signed passthrough
    resp_lat = 2; y_q.push_back(16'h8000); y_q.push_back(16'h7FFF);
    push(16'd1); push(16'd2);
    was = 0;
    for (int n = 0; n < 60 && got.size() < 2; n++) begin
      @(negedge clk);
      if (r_valid_o && !was) got.push_back(r_data_o);
      was = r_valid_o;
      step();
    end
    chk("signed_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("signed_min", 32'(got[0]), 32'h8000);
      chk("signed_max", 32'(got[1]), 32'h7FFF);
    end
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
